delay_word_loader: RTL and testbench

//  Host-side loader that feeds the infinite-mode control/trigger pair.
//  - Assembles 34-bit delay words from 8-bit host bus writes; queues committed words.
//  - Replays each word as DelayVout plus a stretched PSWR_OUT strobe, paced for the slow-clock consumer.
//  - Sits directly upstream of the integrate stage; drives its DelayVin/PSWRIN/EN_IN inputs from CLK214MHz.

---
 rtl/delay_loader_pkg.sv | 16 +
 rtl/delay_word_fifo.sv | 44 ++++
 rtl/delay_word_loader.sv | 136 +++++++++++++
 tb/tb_delay_word_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/delay_loader_pkg.sv
// delay_loader_pkg: shared widths, register map, control bits and pacing FSM states for the delay word loader
package delay_loader_pkg;
    localparam int DW = 34;
    localparam logic [2:0] ADDR_B0    = 3'd0;
    localparam logic [2:0] ADDR_B1    = 3'd1;
    localparam logic [2:0] ADDR_B2    = 3'd2;
    localparam logic [2:0] ADDR_B3    = 3'd3;
    localparam logic [2:0] ADDR_B4    = 3'd4;
    localparam logic [2:0] ADDR_CTRL  = 3'd5;
    localparam logic [2:0] ADDR_FLUSH = 3'd6;
    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_EN     = 1;
    localparam int CTRL_CLR    = 2;
    localparam int FLUSH_BIT   = 0;
    typedef enum logic [1:0] {IDLE, LOAD, STROBE, GAP} state_t;
endpackage

// File: rtl/delay_word_fifo.sv
// delay_word_fifo: synchronous queue of committed delay words with push/pop/flush and level/full/empty
module delay_word_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic [AW:0]  o_level,
    output logic         o_full,
    output logic         o_empty
);
    localparam logic [AW:0] ONE = 1;
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_do_pop;
    logic         w_do_push;
    assign o_level   = r_wr - r_rd;
    assign o_empty   = r_wr == r_rd;
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_data    = r_mem[r_rd[AW-1:0]];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);
    // pointers carry an extra wrap bit so full and empty stay distinguishable; flush empties in one edge
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + ONE;
            if (w_do_pop)  r_rd <= r_rd + ONE;
        end
    end
    // storage needs no reset: only slots between the pointers are ever read
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/delay_word_loader.sv
// delay_word_loader: assembles host-written delay words, queues them and replays each with a paced PSWR strobe (optional DELAY_RANGE_CHECK_EN clamps small words)
module delay_word_loader
    import delay_loader_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int PSWR_CYCLES = 2,
    parameter int GAP_CYCLES  = 8,
    parameter int MIN_DELAY   = 4
) (
    input  logic                        Clock,
    input  logic                        RST_IN,
    input  logic                        Bus_Wr,
    input  logic [2:0]                  Bus_Addr,
    input  logic [7:0]                  Bus_Data,
    output logic [DW-1:0]               DelayVout,
    output logic                        PSWR_OUT,
    output logic                        EN_OUT,
    output logic [$clog2(FIFO_DEPTH):0] Fifo_Level,
    output logic                        Fifo_Full,
    output logic                        Ovf_Err,
    output logic                        Range_Err
);
    localparam int CMAX = (PSWR_CYCLES > GAP_CYCLES) ? PSWR_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX);
`ifdef DELAY_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif
    logic [DW-1:0] r_shadow;
    logic [DW-1:0] w_word;
    logic [DW-1:0] w_head;
    logic          w_small;
    logic          w_ctrl;
    logic          w_commit;
    logic          w_clear;
    logic          w_flush;
    logic          w_pop;
    logic          w_empty;
    logic          w_ovf;
    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    assign w_ctrl   = Bus_Wr && Bus_Addr == ADDR_CTRL;
    assign w_commit = w_ctrl && Bus_Data[CTRL_COMMIT];
    assign w_clear  = w_ctrl && Bus_Data[CTRL_CLR];
    assign w_flush  = Bus_Wr && Bus_Addr == ADDR_FLUSH && Bus_Data[FLUSH_BIT];
    assign w_small  = RANGE_EN && (r_shadow < DW'(MIN_DELAY));
    assign w_word   = w_small ? DW'(MIN_DELAY) : r_shadow;
    assign w_ovf    = w_commit && Fifo_Full && !w_pop;
    delay_word_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (Clock),
        .i_rst   (RST_IN),
        .i_push  (w_commit),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_word),
        .o_data  (w_head),
        .o_level (Fifo_Level),
        .o_full  (Fifo_Full),
        .o_empty (w_empty)
    );
    // shadow word assembled byte by byte; only two bits of the top byte are meaningful
    always_ff @(posedge Clock) begin
        if (RST_IN) begin
            r_shadow <= '0;
        end else if (Bus_Wr) begin
            if (Bus_Addr == ADDR_B0) r_shadow[7:0]   <= Bus_Data;
            if (Bus_Addr == ADDR_B1) r_shadow[15:8]  <= Bus_Data;
            if (Bus_Addr == ADDR_B2) r_shadow[23:16] <= Bus_Data;
            if (Bus_Addr == ADDR_B3) r_shadow[31:24] <= Bus_Data;
            if (Bus_Addr == ADDR_B4) r_shadow[33:32] <= Bus_Data[1:0];
        end
    end
    // enable and sticky error flags; a clear in the same write as a failing commit loses to the new error
    always_ff @(posedge Clock) begin
        if (RST_IN) begin
            EN_OUT    <= 1'b0;
            Ovf_Err   <= 1'b0;
            Range_Err <= 1'b0;
        end else begin
            EN_OUT    <= w_ctrl ? Bus_Data[CTRL_EN] : EN_OUT;
            Ovf_Err   <= w_ovf | (Ovf_Err & ~w_clear);
            Range_Err <= (w_commit & w_small) | (Range_Err & ~w_clear);
        end
    end
    // pacing state and phase counter
    always_ff @(posedge Clock) begin
        if (RST_IN) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end
    // next state: pop on leaving IDLE, then hold the strobe high and the line low for fixed counts
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_pop      = 1'b0;
        case (r_state)
            IDLE: begin
                w_pop  = !w_empty;
                w_next = w_empty ? IDLE : LOAD;
            end
            LOAD: begin
                w_next     = STROBE;
                w_cnt_next = '0;
            end
            STROBE: begin
                w_next     = (r_cnt == CW'(PSWR_CYCLES - 1)) ? GAP : STROBE;
                w_cnt_next = (r_cnt == CW'(PSWR_CYCLES - 1)) ? '0 : r_cnt + CW'(1);
            end
            GAP: begin
                w_next     = (r_cnt == CW'(GAP_CYCLES - 1)) ? IDLE : GAP;
                w_cnt_next = (r_cnt == CW'(GAP_CYCLES - 1)) ? '0 : r_cnt + CW'(1);
            end
            default: begin
                w_next     = IDLE;
                w_cnt_next = '0;
            end
        endcase
    end
    // registered outputs so the downstream domain sees glitch-free word and strobe
    always_ff @(posedge Clock) begin
        if (RST_IN) begin
            DelayVout <= '0;
            PSWR_OUT  <= 1'b0;
        end else begin
            DelayVout <= w_pop ? w_head : DelayVout;
            PSWR_OUT  <= w_next == STROBE;
        end
    end
endmodule

// File: tb/tb_delay_word_loader.sv
// tb_delay_word_loader: random and directed stimulus checked every cycle against a queue-based reference model
module tb_delay_word_loader;
    import delay_loader_pkg::*;
    localparam int D  = 4;
    localparam int P  = 2;
    localparam int G  = 8;
    localparam int MN = 4;
    logic          Clock = 1'b0;
    logic          RST_IN = 1'b1;
    logic          Bus_Wr = 1'b0;
    logic [2:0]    Bus_Addr = '0;
    logic [7:0]    Bus_Data = '0;
    logic [DW-1:0] DelayVout;
    logic          PSWR_OUT;
    logic          EN_OUT;
    logic [2:0]    Fifo_Level;
    logic          Fifo_Full;
    logic          Ovf_Err;
    logic          Range_Err;
    int vectors = 0;
    int errors  = 0;
    logic [DW-1:0] q[$];
    logic [7:0]    sh[5];
    logic [DW-1:0] m_dout;
    logic          m_en;
    logic          m_ovf;
    logic          m_rng;
    int            tmr;

    always #5 Clock = ~Clock;

    delay_word_loader #(.FIFO_DEPTH(D), .PSWR_CYCLES(P), .GAP_CYCLES(G), .MIN_DELAY(MN)) dut (
        .Clock      (Clock),
        .RST_IN     (RST_IN),
        .Bus_Wr     (Bus_Wr),
        .Bus_Addr   (Bus_Addr),
        .Bus_Data   (Bus_Data),
        .DelayVout  (DelayVout),
        .PSWR_OUT   (PSWR_OUT),
        .EN_OUT     (EN_OUT),
        .Fifo_Level (Fifo_Level),
        .Fifo_Full  (Fifo_Full),
        .Ovf_Err    (Ovf_Err),
        .Range_Err  (Range_Err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        Bus_Wr   = 1'b1;
        Bus_Addr = a;
        Bus_Data = d;
        @(negedge Clock);
        Bus_Wr   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic wait_pswr();
        int n = 0;
        while (!PSWR_OUT && n < 40) begin
            @(negedge Clock);
            n++;
        end
        chk("wait_pswr", PSWR_OUT, 1);
    endtask

    // reference: a word queue plus a countdown of cycles until the pacer may take the next word
    always @(posedge Clock) begin
        if (RST_IN) begin
            q.delete();
            for (int i = 0; i < 5; i++) sh[i] = 8'h00;
            m_dout = '0;
            m_en   = 1'b0;
            m_ovf  = 1'b0;
            m_rng  = 1'b0;
            tmr    = 0;
        end else begin
            logic [DW-1:0] w;
            if (tmr == 0 && q.size() != 0) begin
                m_dout = q.pop_front();
                tmr    = 1 + P + G;
            end else if (tmr != 0) begin
                tmr--;
            end
            if (Bus_Wr) begin
                if (Bus_Addr <= 3'd3) sh[Bus_Addr] = Bus_Data;
                if (Bus_Addr == 3'd4) sh[4] = Bus_Data & 8'h03;
                if (Bus_Addr == 3'd5) begin
                    if (Bus_Data[2]) begin
                        m_ovf = 1'b0;
                        m_rng = 1'b0;
                    end
                    m_en = Bus_Data[1];
                    if (Bus_Data[0]) begin
                        w = {sh[4][1:0], sh[3], sh[2], sh[1], sh[0]};
`ifdef DELAY_RANGE_CHECK_EN
                        if (w < MN) begin
                            w = MN;
                            m_rng = 1'b1;
                        end
`endif
                        if (q.size() < D) q.push_back(w);
                        else m_ovf = 1'b1;
                    end
                end
                if (Bus_Addr == 3'd6 && Bus_Data[0]) q.delete();
            end
        end
        #1;
        chk("dout",  DelayVout, m_dout);
        chk("pswr",  PSWR_OUT, logic'(tmr > G && tmr <= G + P));
        chk("en",    EN_OUT, m_en);
        chk("level", Fifo_Level, q.size());
        chk("full",  Fifo_Full, logic'(q.size() == D));
        chk("ovf",   Ovf_Err, m_ovf);
        chk("rng",   Range_Err, m_rng);
    end

    initial begin
        int n;
        repeat (3) @(negedge Clock);
        RST_IN = 1'b0;
        chk("rst_level", Fifo_Level, 0);
        chk("rst_dout", DelayVout, 0);
        chk("rst_pswr", PSWR_OUT, 0);
        // single word, latency and strobe width
        wr(3'd0, 8'h0A); wr(3'd1, 8'h00); wr(3'd2, 8'h00); wr(3'd3, 8'h00); wr(3'd4, 8'h00);
        wr(3'd5, 8'h03);
        chk("t1_level", Fifo_Level, 1);
        @(negedge Clock);
        chk("t1_dout", DelayVout, 34'd10);
        chk("t1_model_dout", m_dout, 34'd10);
        chk("t1_pswr_lo", PSWR_OUT, 0);
        @(negedge Clock);
        chk("t1_pswr_hi1", PSWR_OUT, 1);
        @(negedge Clock);
        chk("t1_pswr_hi2", PSWR_OUT, 1);
        @(negedge Clock);
        chk("t1_pswr_end", PSWR_OUT, 0);
        chk("t1_en", EN_OUT, 1);
        idle(16);
        // top byte masked to two bits
        wr(3'd4, 8'hFF); wr(3'd5, 8'h03);
        @(negedge Clock);
        chk("t3_dout", DelayVout, 34'h3_0000_000A);
        idle(14);
        // small word, clamped only with the range check build
        wr(3'd0, 8'h02); wr(3'd4, 8'h00); wr(3'd5, 8'h03);
        @(negedge Clock);
`ifdef DELAY_RANGE_CHECK_EN
        chk("t4_dout", DelayVout, 34'd4);
        chk("t4_model_dout", m_dout, 34'd4);
        chk("t4_rng", Range_Err, 1);
`else
        chk("t4_dout", DelayVout, 34'd2);
        chk("t4_model_dout", m_dout, 34'd2);
        chk("t4_rng", Range_Err, 0);
`endif
        idle(14);
        wr(3'd5, 8'h06);
        // overflow: six back-to-back commits, one drained, four queued, last dropped
        wr(3'd0, 8'h20);
        repeat (6) wr(3'd5, 8'h03);
        chk("t2_ovf", Ovf_Err, 1);
        chk("t2_model_ovf", m_ovf, 1);
        chk("t2_level", Fifo_Level, 4);
        chk("t2_full", Fifo_Full, 1);
        idle(60);
        chk("t2_drained", Fifo_Level, 0);
        wr(3'd5, 8'h06);
        chk("t2_clear", Ovf_Err, 0);
        idle(4);
        // flush during the first strobe
        repeat (3) wr(3'd5, 8'h03);
        wait_pswr();
        n = 1;
        wr(3'd6, 8'h01);
        chk("t5_level", Fifo_Level, 0);
        n += PSWR_OUT;
        repeat (30) begin
            @(negedge Clock);
            n += PSWR_OUT;
        end
        chk("t5_strobe_cycles", n, P);
        // reset mid-strobe
        wr(3'd5, 8'h03); wr(3'd5, 8'h03);
        wait_pswr();
        RST_IN = 1'b1;
        @(negedge Clock);
        chk("t6_pswr", PSWR_OUT, 0);
        chk("t6_dout", DelayVout, 0);
        chk("t6_level", Fifo_Level, 0);
        chk("t6_en", EN_OUT, 0);
        RST_IN = 1'b0;
        // random traffic
        repeat (3000) begin
            Bus_Wr   = ($urandom % 3) == 0;
            Bus_Addr = 3'($urandom % 8);
            Bus_Data = 8'($urandom);
            if (Bus_Addr == 3'd6 && ($urandom % 4) != 0) Bus_Data[0] = 1'b0;
            if (Bus_Addr == 3'd5 && ($urandom % 2) == 0) Bus_Data[0] = 1'b1;
            if (Bus_Addr <= 3'd4 && ($urandom % 3) == 0) Bus_Data = 8'($urandom % 6);
            RST_IN   = ($urandom % 500) == 0;
            @(negedge Clock);
        end
        Bus_Wr = 1'b0;
        RST_IN = 1'b0;
        @(negedge Clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
